// File: rtl/lcd_pkg.sv
// Shared geometry, control codes and FSM state types for the LCD text buffer.
package lcd_pkg;

    localparam int unsigned LINE_WIDTH = 16;
    localparam int unsigned LINES      = 4;
    localparam int unsigned MEM_DEPTH  = LINE_WIDTH * LINES;
    localparam int unsigned ADDR_BITS  = $clog2(MEM_DEPTH);
    localparam int unsigned DATA_BITS  = 8;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic {
        M_CLEAR,
        M_IDLE
    } main_state_t;

    typedef enum logic [1:0] {
        T_ARMED,
        T_WAIT_HI,
        T_WAIT_LO
    } trg_state_t;

    // CGRAM slots 0x00-0x07 and everything from space upward are stored as characters
    function automatic logic is_printable(input logic [7:0] b);
        return (b <= 8'h07) || (b >= 8'h20);
    endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Byte stream handshake feeding the text buffer.
interface lcd_text_buffer_if;
    import lcd_pkg::*;

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/lcd_char_ram.sv
// Character store: one synchronous write port, one registered read-before-write port.
module lcd_char_ram #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdata <= '0;
        else      r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_text_buffer.sv
// Text frame buffer ahead of the HD44780 driver: decodes the byte stream into a
// cursor-addressed character store and schedules refresh triggers.
module lcd_text_buffer #(
    parameter int unsigned LINE_WIDTH   = lcd_pkg::LINE_WIDTH,
    parameter int unsigned LINES        = lcd_pkg::LINES,
    parameter logic [7:0]  FILL_CHAR    = 8'h20,
    parameter bit          AUTO_REFRESH = 1'b1,
    localparam int unsigned MEM_DEPTH   = LINE_WIDTH * LINES,
    localparam int unsigned ADDR_BITS   = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_text_buffer_if.slave     in_if,
    input  logic                 refresh_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data,
    input  logic                 lcd_busy,
    output logic                 lcd_trg,
    output logic [ADDR_BITS-1:0] cursor,
    output logic                 dirty
);
    import lcd_pkg::*;

    localparam int unsigned COL_BITS  = $clog2(LINE_WIDTH);
    localparam int unsigned LINE_BITS = $clog2(LINES);

    main_state_t r_state, w_state_next;
    trg_state_t  r_trg_state, w_trg_next;

    logic                 r_in_ready;
    logic [ADDR_BITS-1:0] r_cursor, w_cursor_next;
    logic [ADDR_BITS-1:0] r_clear_addr;
    logic                 r_dirty;
    logic                 r_lcd_trg;
    logic                 r_refresh_latched;

    logic                 w_accept;
    logic                 w_clear_done;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_waddr;
    logic [7:0]           w_wdata;
    logic                 w_set_dirty;
    logic                 w_fire;
    logic [LINE_BITS-1:0] w_line;

    assign w_line       = r_cursor[ADDR_BITS-1 -: LINE_BITS];
    assign w_accept     = in_if.in_valid & r_in_ready;
    assign w_clear_done = (r_state == M_CLEAR) && (r_clear_addr == ADDR_BITS'(MEM_DEPTH - 1));

    // Main FSM state register; in_ready mirrors the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= M_CLEAR;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == M_IDLE);
        end
    end

    // Main FSM next state, control-code decode and write strobe
    always_comb begin
        w_state_next  = r_state;
        w_cursor_next = r_cursor;
        w_we          = 1'b0;
        w_waddr       = r_cursor;
        w_wdata       = in_if.in_data;
        w_set_dirty   = 1'b0;
        case (r_state)
            M_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clear_addr;
                w_wdata = FILL_CHAR;
                if (w_clear_done) begin
                    w_state_next  = M_IDLE;
                    w_cursor_next = '0;
                    w_set_dirty   = 1'b1;
                end
            end
            M_IDLE: begin
                if (w_accept) begin
                    case (in_if.in_data)
                        CC_FF: w_state_next  = M_CLEAR;
                        CC_CR: w_cursor_next = {w_line, COL_BITS'(0)};
                        CC_LF: w_cursor_next = {LINE_BITS'(w_line + LINE_BITS'(1)), COL_BITS'(0)};
                        CC_BS: w_cursor_next = r_cursor - ADDR_BITS'(1);
                        default: begin
                            if (is_printable(in_if.in_data)) begin
                                w_we          = 1'b1;
                                w_cursor_next = r_cursor + ADDR_BITS'(1);
                                w_set_dirty   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: w_state_next = M_CLEAR;
        endcase
    end

    // Trigger FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_trg_state <= T_ARMED;
        else      r_trg_state <= w_trg_next;
    end

    // Trigger FSM: fire once, then follow the driver's busy high/low cycle
    always_comb begin
        w_trg_next = r_trg_state;
        w_fire     = 1'b0;
        case (r_trg_state)
            T_ARMED: begin
                if (((AUTO_REFRESH && r_dirty) || r_refresh_latched || refresh_req)
                    && !lcd_busy && (r_state == M_IDLE)) begin
                    w_fire     = 1'b1;
                    w_trg_next = T_WAIT_HI;
                end
            end
            T_WAIT_HI: if (lcd_busy)  w_trg_next = T_WAIT_LO;
            T_WAIT_LO: if (!lcd_busy) w_trg_next = T_ARMED;
            default:   w_trg_next = T_ARMED;
        endcase
    end

    // Cursor, clear counter, dirty flag (set beats clear) and refresh latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cursor          <= '0;
            r_clear_addr      <= '0;
            r_dirty           <= 1'b0;
            r_refresh_latched <= 1'b0;
            r_lcd_trg         <= 1'b0;
        end else begin
            r_cursor          <= w_cursor_next;
            r_clear_addr      <= (r_state == M_CLEAR) ? r_clear_addr + ADDR_BITS'(1) : '0;
            r_dirty           <= w_set_dirty | (r_dirty & ~w_fire);
            r_refresh_latched <= ~w_fire & (r_refresh_latched | refresh_req);
            r_lcd_trg         <= w_fire;
        end
    end

    lcd_char_ram #(
        .DEPTH     (MEM_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (8)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign in_if.in_ready = r_in_ready;
    assign lcd_trg        = r_lcd_trg;
    assign cursor         = r_cursor;
    assign dirty          = r_dirty;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: one auto-refresh instance, one request-only instance.
module tb_lcd_text_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_text_buffer_if in_a ();
    lcd_text_buffer_if in_b ();

    logic       refresh_req_a, refresh_req_b;
    logic [5:0] rd_addr_a, rd_addr_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       lcd_busy_a, lcd_busy_b;
    logic       lcd_trg_a, lcd_trg_b;
    logic [5:0] cursor_a, cursor_b;
    logic       dirty_a, dirty_b;

    int checks = 0;
    int passed = 0;

    lcd_text_buffer #(.AUTO_REFRESH(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .in_if(in_a), .refresh_req(refresh_req_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .lcd_busy(lcd_busy_a),
        .lcd_trg(lcd_trg_a), .cursor(cursor_a), .dirty(dirty_a)
    );

    lcd_text_buffer #(.AUTO_REFRESH(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_if(in_b), .refresh_req(refresh_req_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .lcd_busy(lcd_busy_b),
        .lcd_trg(lcd_trg_b), .cursor(cursor_b), .dirty(dirty_b)
    );

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_a.in_data  = b;
        in_a.in_valid = 1'b1;
        while (!in_a.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL send_byte_timeout: in_ready never rose for byte %h", b);
        end
        @(posedge clk);
        #1 in_a.in_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [5:0] addr, output logic [7:0] d);
        @(negedge clk);
        rd_addr_a = addr;
        @(negedge clk);
        d = rd_data_a;
    endtask

    // Caller must be sitting on a negedge
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_a.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_trg(input int cycles, output int na, output int nb);
        na = 0;
        nb = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (lcd_trg_a) na++;
            if (lcd_trg_b) nb++;
        end
    endtask

    task automatic count_fill(output int errs);
        logic [7:0] d;
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            read_cell(6'(i), d);
            if (d !== 8'h20) errs++;
        end
    endtask

    task automatic test_reset;
        int n, na, nb, errs;
        repeat (3) @(negedge clk);
        checks++; if (in_a.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_a.in_ready); else passed++;
        checks++; if (rd_data_a !== 8'h00) $display("FAIL rst_rd_data: got %h want 00", rd_data_a); else passed++;
        checks++; if (lcd_trg_a !== 1'b0) $display("FAIL rst_lcd_trg: got %b want 0", lcd_trg_a); else passed++;
        checks++; if (cursor_a !== 6'd0) $display("FAIL rst_cursor: got %h want 00", cursor_a); else passed++;
        checks++; if (dirty_a !== 1'b0) $display("FAIL rst_dirty: got %b want 0", dirty_a); else passed++;
        rst = 1'b1;
        wait_ready(n);
        checks++; if (n !== 64) $display("FAIL clear_len: got %0d want 64", n); else passed++;
        checks++; if (dirty_a !== 1'b1) $display("FAIL clear_dirty_a: got %b want 1", dirty_a); else passed++;
        checks++; if (dirty_b !== 1'b1) $display("FAIL clear_dirty_b: got %b want 1", dirty_b); else passed++;
        count_trg(10, na, nb);
        checks++; if (na !== 1) $display("FAIL auto_trg_after_clear: got %0d want 1", na); else passed++;
        checks++; if (nb !== 0) $display("FAIL noauto_trg_after_clear: got %0d want 0", nb); else passed++;
        checks++; if (dirty_a !== 1'b0) $display("FAIL dirty_after_trg: got %b want 0", dirty_a); else passed++;
        lcd_busy_a = 1'b1;
        repeat (3) @(negedge clk);
        lcd_busy_a = 1'b0;
        @(negedge clk);
        count_fill(errs);
        checks++; if (errs !== 0) $display("FAIL reset_fill: got %0d bad cells want 0", errs); else passed++;
    endtask

    task automatic test_stream_ab;
        lcd_busy_a = 1'b1;
        send_byte(8'h41);
        send_byte(8'h42);
        @(negedge clk);
        checks++; if (cursor_a !== 6'd2) $display("FAIL ab_cursor: got %h want 02", cursor_a); else passed++;
        rd_addr_a = 6'd0;
        @(negedge clk);
        rd_addr_a = 6'd1;
        checks++; if (rd_data_a !== 8'h41) $display("FAIL ab_mem0: got %h want 41", rd_data_a); else passed++;
        @(negedge clk);
        checks++; if (rd_data_a !== 8'h42) $display("FAIL ab_mem1_latency: got %h want 42", rd_data_a); else passed++;
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        repeat (3) send_byte(8'h08);
        @(negedge clk);
        checks++; if (cursor_a !== 6'd63) $display("FAIL bs_wrap_cursor: got %h want 3f", cursor_a); else passed++;
        send_byte(8'h5A);
        @(negedge clk);
        checks++; if (cursor_a !== 6'd0) $display("FAIL wrap_cursor: got %h want 00", cursor_a); else passed++;
        read_cell(6'd63, d);
        checks++; if (d !== 8'h5A) $display("FAIL wrap_mem63: got %h want 5a", d); else passed++;
        read_cell(6'd0, d);
        checks++; if (d !== 8'h41) $display("FAIL bs_no_write: got %h want 41", d); else passed++;
    endtask

    task automatic test_control;
        logic [7:0] d;
        send_byte(8'h0A);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h10) $display("FAIL lf_line0: got %h want 10", cursor_a); else passed++;
        for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i));
        @(negedge clk);
        checks++; if (cursor_a !== 6'h17) $display("FAIL text_cursor: got %h want 17", cursor_a); else passed++;
        send_byte(8'h0A);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h20) $display("FAIL lf_cursor: got %h want 20", cursor_a); else passed++;
        send_byte(8'h0D);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h20) $display("FAIL cr_cursor: got %h want 20", cursor_a); else passed++;
        send_byte(8'h08);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h1F) $display("FAIL bs_cursor: got %h want 1f", cursor_a); else passed++;
        read_cell(6'h1F, d);
        checks++; if (d !== 8'h20) $display("FAIL bs_mem_unchanged: got %h want 20", d); else passed++;
        send_byte(8'h09);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h1F) $display("FAIL ignored_code: got %h want 1f", cursor_a); else passed++;
        send_byte(8'h03);
        read_cell(6'h1F, d);
        checks++; if (d !== 8'h03) $display("FAIL cgram_write: got %h want 03", d); else passed++;
        send_byte(8'h0A);
        send_byte(8'h0A);
        @(negedge clk);
        checks++; if (cursor_a !== 6'h00) $display("FAIL lf_last_line_wrap: got %h want 00", cursor_a); else passed++;
        read_cell(6'h16, d);
        checks++; if (d !== 8'h36) $display("FAIL text_mem16: got %h want 36", d); else passed++;
    endtask

    task automatic test_form_feed;
        int n, errs;
        send_byte(8'h51);
        send_byte(8'h0C);
        @(negedge clk);
        wait_ready(n);
        checks++; if (n !== 64) $display("FAIL ff_clear_len: got %0d want 64", n); else passed++;
        checks++; if (cursor_a !== 6'd0) $display("FAIL ff_cursor: got %h want 00", cursor_a); else passed++;
        checks++; if (dirty_a !== 1'b1) $display("FAIL ff_dirty: got %b want 1", dirty_a); else passed++;
        count_fill(errs);
        checks++; if (errs !== 0) $display("FAIL ff_fill: got %0d bad cells want 0", errs); else passed++;
    endtask

    task automatic test_handshake;
        int na, nb;
        send_byte(8'h48);
        count_trg(10, na, nb);
        checks++; if (na !== 0) $display("FAIL busy_blocks_trg: got %0d want 0", na); else passed++;
        lcd_busy_a = 1'b0;
        count_trg(10, na, nb);
        checks++; if (na !== 1) $display("FAIL trg_after_busy_drop: got %0d want 1", na); else passed++;
        checks++; if (dirty_a !== 1'b0) $display("FAIL dirty_cleared: got %b want 0", dirty_a); else passed++;
        lcd_busy_a = 1'b1;
        send_byte(8'h49);
        count_trg(5, na, nb);
        checks++; if (na !== 0) $display("FAIL trg_during_refresh: got %0d want 0", na); else passed++;
        checks++; if (dirty_a !== 1'b1) $display("FAIL dirty_during_refresh: got %b want 1", dirty_a); else passed++;
        lcd_busy_a = 1'b0;
        count_trg(10, na, nb);
        checks++; if (na !== 1) $display("FAIL follow_up_trg: got %0d want 1", na); else passed++;
        lcd_busy_a = 1'b1;
        repeat (2) @(negedge clk);
        lcd_busy_a = 1'b0;
        count_trg(10, na, nb);
        checks++; if (na !== 0) $display("FAIL no_spurious_trg: got %0d want 0", na); else passed++;
    endtask

    task automatic test_refresh_req;
        int na, nb, t;
        refresh_req_b = 1'b1;
        @(negedge clk);
        refresh_req_b = 1'b0;
        nb = lcd_trg_b ? 1 : 0;
        count_trg(5, na, t);
        nb += t;
        checks++; if (nb !== 1) $display("FAIL req_first: got %0d want 1", nb); else passed++;
        checks++; if (dirty_b !== 1'b0) $display("FAIL req_dirty_cleared: got %b want 0", dirty_b); else passed++;
        lcd_busy_b = 1'b1;
        repeat (2) @(negedge clk);
        lcd_busy_b = 1'b0;
        repeat (2) @(negedge clk);
        refresh_req_b = 1'b1;
        @(negedge clk);
        refresh_req_b = 1'b0;
        nb = lcd_trg_b ? 1 : 0;
        count_trg(5, na, t);
        nb += t;
        checks++; if (nb !== 1) $display("FAIL req_dirty0: got %0d want 1", nb); else passed++;
        lcd_busy_b = 1'b1;
        @(negedge clk);
        refresh_req_b = 1'b1;
        @(negedge clk);
        refresh_req_b = 1'b0;
        count_trg(5, na, nb);
        checks++; if (nb !== 0) $display("FAIL req_latched_busy: got %0d want 0", nb); else passed++;
        lcd_busy_b = 1'b0;
        count_trg(5, na, nb);
        checks++; if (nb !== 1) $display("FAIL req_latched_fire: got %0d want 1", nb); else passed++;
    endtask

    initial begin
        in_a.in_data  = 8'h00;
        in_a.in_valid = 1'b0;
        in_b.in_data  = 8'h00;
        in_b.in_valid = 1'b0;
        refresh_req_a = 1'b0;
        refresh_req_b = 1'b0;
        rd_addr_a     = 6'd0;
        rd_addr_b     = 6'd0;
        lcd_busy_a    = 1'b0;
        lcd_busy_b    = 1'b0;

        test_reset();
        test_stream_ab();
        test_wrap();
        test_control();
        test_form_feed();
        test_handshake();
        test_refresh_req();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Character frame buffer that sits directly upstream of the HD44780 4-bit driver.
- Accepts a byte stream over a valid/ready handshake and interprets control codes to move a cursor.
- Stores 64 characters (4 lines x 16) and serves them to the driver through a registered read port.
- Issues a one-cycle refresh trigger to the driver whenever the content has changed and the driver is idle.

Parameters:
- LINE_WIDTH, 16, characters per line; must be a power of two.
- LINES, 4, number of display lines; must be a power of two.
- FILL_CHAR, 8'h20, byte written on clear.
- AUTO_REFRESH, 1, 1 = generate lcd_trg automatically from the dirty flag; 0 = only on refresh_req.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_data  in  8  character or control byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  buffer accepts a byte this cycle
- refresh_req  in  1  force a refresh; single-cycle pulse
- rd_addr  in  6  driver read address (log2(LINE_WIDTH*LINES) bits)
- rd_data  out  8  mem[rd_addr], registered, 1-cycle latency
- lcd_busy  in  1  driver busy, from the driver's busy output
- lcd_trg  out  1  one-cycle refresh pulse to the driver
- cursor  out  6  current write position
- dirty  out  1  content changed since last trigger

Behaviour:
- Reset values: in_ready=0, rd_data=0, lcd_trg=0, cursor=0, dirty=0. Main FSM goes to CLEAR, trigger FSM to ARMED.
- A byte is accepted on a cycle where in_valid & in_ready; one byte per cycle at most.
- Main FSM, CLEAR state:
  - in_ready=0; clear_addr counts 0..63 and writes FILL_CHAR, one address per cycle.
  - After the write to 63: cursor<=0, dirty<=1, go to IDLE.
  - Duration is exactly 64 cycles.
- Main FSM, IDLE state: in_ready=1. Accepted bytes are handled as follows:
  - 0x0C (form feed): go to CLEAR. The byte is consumed; in_ready drops the next cycle.
  - 0x0D (carriage return): cursor <= {line, 0}.
  - 0x0A (line feed): cursor <= {line+1 mod LINES, 0}.
  - 0x08 (backspace): cursor <= cursor-1 mod 64; no write.
  - 0x00-0x07 (CGRAM characters) and 0x20-0xFF: mem[cursor]<=byte, cursor <= cursor+1 mod 64 (63 wraps to 0), dirty<=1.
  - 0x09, 0x0B, 0x0E-0x1F: consumed, no effect.
  - line = cursor[5:4].
- Read port:
  - rd_data <= mem[rd_addr] every cycle; independent of the FSM and always valid.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- Trigger FSM, ARMED:
  - Fires when (AUTO_REFRESH & dirty | refresh_req_latched) & !lcd_busy & main FSM in IDLE.
  - On firing: lcd_trg=1 for one cycle, dirty<=0, refresh latch cleared, go to WAIT_HI.
- Trigger FSM, WAIT_HI: wait for lcd_busy=1, then go to WAIT_LO.
- Trigger FSM, WAIT_LO: wait for lcd_busy=0, then go to ARMED.
- No trigger is issued while lcd_busy is high. This covers the driver's initial power-on busy period.
- refresh_req is latched if it arrives while the trigger FSM is not ARMED or the driver is busy.
- Simultaneous write and trigger: the dirty set wins, so dirty stays 1 and a new refresh follows the current one.
- Writes during a refresh are allowed. The driver may display a mix of old and new content; the re-set dirty flag guarantees a follow-up refresh.
- Reset asserted mid-CLEAR or mid-refresh aborts immediately to the reset values. Memory contents are undefined until the CLEAR after reset completes.

Decomposition:
- Package lcd_pkg holds:
  - LINE_WIDTH, LINES, MEM_DEPTH, ADDR_BITS=$clog2(MEM_DEPTH).
  - Control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - Main and trigger FSM state enumerations.
- Sub-module lcd_char_ram:
  - 64x8, one synchronous write port and one registered read port, read-before-write.
  - No reset on the array; rd_data register resets to 0.
- Control-code decoding, cursor update and both FSMs stay in the top module.

Test Plan:
- Reset release with lcd_busy=0:
  - in_ready=0 for 64 cycles, then 1.
  - All 64 reads return 8'h20; dirty=1.
  - One lcd_trg pulse follows.
- Stream "AB":
  - mem[0]=8'h41, mem[1]=8'h42, cursor=2.
  - rd_addr=1 gives rd_data=8'h42 on the next cycle.
- Wrap-around: cursor=63, write 8'h5A -> mem[63]=8'h5A, cursor=0.
- Control codes: cursor=0x17, send 0x0A -> cursor=0x20; then 0x0D -> 0x20; then 0x08 -> 0x1F, no memory change.
- Form feed: send 0x0C mid-text -> in_ready low for 64 cycles, all cells 8'h20, cursor=0, dirty=1.
- Handshake:
  - Hold lcd_busy=1 while writing: no lcd_trg.
  - Drop lcd_busy: exactly one lcd_trg pulse.
  - Write during the next busy window: a second pulse after busy falls.
  - refresh_req with dirty=0 and AUTO_REFRESH=0: one pulse.
